// File: rtl/promediador_ctrl_pkg.sv
// Shared types and constants for the 3x3 averaging window sequencer.
// The window is nine RGB444 pixels packed into 108 bits, center slot on top.
package promediador_pkg;

   localparam int PIX_W = 12;
   localparam int WIN_W = 108;

   // Bit offsets of each neighbour inside the 108-bit window
   localparam int CENTER = 96;
   localparam int LEFT   = 84;
   localparam int RIGHT  = 72;
   localparam int UP     = 60;
   localparam int DOWN   = 48;
   localparam int UL     = 36;
   localparam int UR     = 24;
   localparam int DL     = 12;
   localparam int DR     = 0;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [2:0] {RUN, EOL, FLUSH, FLUSH_EOL, DRAIN} state_t;

   // One window column: the pixel above, at, and below the center row
   typedef struct packed {
      pixel_t up;
      pixel_t mid;
      pixel_t dn;
   } column_t;

   // Assemble a window from its left, center and right columns
   function automatic logic [WIN_W-1:0] pack_window(input column_t l,
                                                    input column_t c,
                                                    input column_t r);
      logic [WIN_W-1:0] w;
      w = '0;
      w[CENTER +: PIX_W] = c.mid;
      w[LEFT   +: PIX_W] = l.mid;
      w[RIGHT  +: PIX_W] = r.mid;
      w[UP     +: PIX_W] = c.up;
      w[DOWN   +: PIX_W] = c.dn;
      w[UL     +: PIX_W] = l.up;
      w[UR     +: PIX_W] = r.up;
      w[DL     +: PIX_W] = l.dn;
      w[DR     +: PIX_W] = r.dn;
      return w;
   endfunction

endpackage

// File: rtl/promediador_ctrl_if.sv
// Pixel stream in, window and output-tracking signals out.
// The slave modport is the controller's view, master is the pixel source/consumer.
interface promediador_ctrl_if #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120
);
   import promediador_pkg::*;

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   pixel_t           pix_in;
   logic             pix_valid;
   logic             pix_ready;
   logic [WIN_W-1:0] win_data;
   logic             win_valid;
   logic             out_valid;
   logic [XW-1:0]    out_x;
   logic [YW-1:0]    out_y;
   logic             frame_done;

   modport master (
      output pix_in, pix_valid,
      input  pix_ready, win_data, win_valid, out_valid, out_x, out_y, frame_done
   );

   modport slave (
      input  pix_in, pix_valid,
      output pix_ready, win_data, win_valid, out_valid, out_x, out_y, frame_done
   );

endinterface

// File: rtl/promediador_ctrl_line_buffer.sv
// One line of pixels with a registered read port.
// A read and a write in the same cycle at the same address return the old data.
module line_buffer
   import promediador_pkg::*;
#(
   parameter int DEPTH = 160,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  pixel_t        wr_data,
   input  logic [AW-1:0] rd_addr,
   output pixel_t        rd_data
);

   pixel_t mem [DEPTH];

   // Storage write and registered read; contents need no reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/promediador_ctrl.sv
// Window sequencer for the 3x3 averaging filter.
// Buffers two previous lines, builds border-replicated windows in raster
// order, and delays valid/coordinates to line up with the filter output.
module promediador_ctrl
   import promediador_pkg::*;
#(
   parameter int WIDTH          = 160,
   parameter int HEIGHT         = 120,
   parameter int FILTER_LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   promediador_ctrl_if.slave bus
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int DW = (FILTER_LATENCY > 1) ? $clog2(FILTER_LATENCY) : 1;
   localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
   localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
   localparam logic [DW-1:0] DMAX = DW'(FILTER_LATENCY - 1);

   state_t           state;
   logic [XW-1:0]    xi;
   logic [YW-1:0]    yi;
   logic [YW-1:0]    eol_row;
   logic [XW-1:0]    fx;
   logic [DW-1:0]    drain_cnt;
   column_t          c1;
   column_t          c2;
   logic             pix_ready_q;
   logic [WIN_W-1:0] win_data_q;
   logic             win_valid_q;
   logic [XW-1:0]    win_x_q;
   logic [YW-1:0]    win_y_q;
   logic             win_last_q;

   logic             accept;
   logic [XW-1:0]    rd_addr;
   pixel_t           rd_a;
   pixel_t           rd_b;
   column_t          col_run;
   column_t          col_flush;

   logic [FILTER_LATENCY-1:0] dly_valid;
   logic [FILTER_LATENCY-1:0] dly_last;
   logic [XW-1:0]             dly_x [FILTER_LATENCY];
   logic [YW-1:0]             dly_y [FILTER_LATENCY];

   assign accept = bus.pix_valid && pix_ready_q && (state == RUN);

   // buf_cur holds the row above the incoming one; buf_prev the row above that
   line_buffer #(.DEPTH(WIDTH)) buf_cur (
      .clk     (clk),
      .we      (accept),
      .wr_addr (xi),
      .wr_data (bus.pix_in),
      .rd_addr (rd_addr),
      .rd_data (rd_a)
   );

   line_buffer #(.DEPTH(WIDTH)) buf_prev (
      .clk     (clk),
      .we      (accept),
      .wr_addr (xi),
      .wr_data (rd_a),
      .rd_addr (rd_addr),
      .rd_data (rd_b)
   );

   // Incoming column: row 1 has no row above its upper neighbour, so it clamps to row 0
   assign col_run   = '{up: (yi == YW'(1)) ? rd_a : rd_b, mid: rd_a, dn: bus.pix_in};
   // Last-row column: nothing below, so the down pixel replicates the center row
   assign col_flush = '{up: rd_b, mid: rd_a, dn: rd_a};

   // Read address looks one column ahead so the registered read is ready when needed
   always_comb begin
      rd_addr = xi;
      case (state)
         RUN:     if (accept) rd_addr = (xi == XMAX) ? '0 : xi + 1'b1;
         EOL:     rd_addr = (eol_row == YMAX) ? XW'(1) : '0;
         FLUSH:   rd_addr = (fx == XMAX) ? '0 : fx + 1'b1;
         default: rd_addr = '0;
      endcase
   end

   // Sequencer: counters, column shift, window emission and handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         xi          <= '0;
         yi          <= '0;
         eol_row     <= '0;
         fx          <= '0;
         drain_cnt   <= '0;
         c1          <= '0;
         c2          <= '0;
         pix_ready_q <= 1'b1;
         win_data_q  <= '0;
         win_valid_q <= 1'b0;
         win_x_q     <= '0;
         win_y_q     <= '0;
         win_last_q  <= 1'b0;
      end else begin
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         case (state)
            RUN: begin
               if (accept) begin
                  if (xi != '0 && yi != '0) begin
                     win_valid_q <= 1'b1;
                     win_data_q  <= pack_window((xi == XW'(1)) ? c1 : c2, c1, col_run);
                     win_x_q     <= xi - 1'b1;
                     win_y_q     <= yi - 1'b1;
                  end
                  c2 <= c1;
                  c1 <= col_run;
                  if (xi == XMAX) begin
                     xi          <= '0;
                     eol_row     <= yi;
                     if (yi != YMAX) yi <= yi + 1'b1;
                     state       <= EOL;
                     pix_ready_q <= 1'b0;
                  end else begin
                     xi <= xi + 1'b1;
                  end
               end
            end
            EOL: begin
               if (eol_row != '0) begin
                  win_valid_q <= 1'b1;
                  win_data_q  <= pack_window(c2, c1, c1);
                  win_x_q     <= XMAX;
                  win_y_q     <= eol_row - 1'b1;
               end
               if (eol_row == YMAX) begin
                  state <= FLUSH;
                  fx    <= XW'(1);
                  c1    <= col_flush;
               end else begin
                  state       <= RUN;
                  pix_ready_q <= 1'b1;
               end
            end
            FLUSH: begin
               win_valid_q <= 1'b1;
               win_data_q  <= pack_window((fx == XW'(1)) ? c1 : c2, c1, col_flush);
               win_x_q     <= fx - 1'b1;
               win_y_q     <= YMAX;
               c2          <= c1;
               c1          <= col_flush;
               if (fx == XMAX) begin
                  state <= FLUSH_EOL;
               end else begin
                  fx <= fx + 1'b1;
               end
            end
            FLUSH_EOL: begin
               win_valid_q <= 1'b1;
               win_data_q  <= pack_window(c2, c1, c1);
               win_x_q     <= XMAX;
               win_y_q     <= YMAX;
               win_last_q  <= 1'b1;
               drain_cnt   <= '0;
               state       <= DRAIN;
            end
            DRAIN: begin
               if (drain_cnt == DMAX) begin
                  state       <= RUN;
                  pix_ready_q <= 1'b1;
                  xi          <= '0;
                  yi          <= '0;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: begin
               state       <= RUN;
               pix_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Delay line that tracks the filter pipeline so outputs align with its result
   always_ff @(posedge clk) begin
      if (reset) begin
         dly_valid <= '0;
         dly_last  <= '0;
         for (int i = 0; i < FILTER_LATENCY; i++) begin
            dly_x[i] <= '0;
            dly_y[i] <= '0;
         end
      end else begin
         dly_valid[0] <= win_valid_q;
         dly_last[0]  <= win_last_q;
         dly_x[0]     <= win_x_q;
         dly_y[0]     <= win_y_q;
         for (int i = 1; i < FILTER_LATENCY; i++) begin
            dly_valid[i] <= dly_valid[i-1];
            dly_last[i]  <= dly_last[i-1];
            dly_x[i]     <= dly_x[i-1];
            dly_y[i]     <= dly_y[i-1];
         end
      end
   end

   assign bus.pix_ready  = pix_ready_q;
   assign bus.win_data   = win_data_q;
   assign bus.win_valid  = win_valid_q;
   assign bus.out_valid  = dly_valid[FILTER_LATENCY-1];
   assign bus.out_x      = dly_x[FILTER_LATENCY-1];
   assign bus.out_y      = dly_y[FILTER_LATENCY-1];
   assign bus.frame_done = dly_last[FILTER_LATENCY-1];

endmodule

// File: tb/tb_promediador_ctrl.sv
// Bench for promediador_ctrl on a 4x3 frame with a latency-4 averaging filter.
// Expected windows and averages come from a frame array with clamped indexing.
module tb_promediador_ctrl;

   localparam int W   = 4;
   localparam int H   = 3;
   localparam int LAT = 4;

   localparam int DXT [9] = '{0, -1, 1, 0, 0, -1, 1, -1, 1};
   localparam int DYT [9] = '{0, 0, 0, -1, 1, -1, -1, 1, 1};

   typedef struct packed {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [11:0] v;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   promediador_ctrl_if #(.WIDTH(W), .HEIGHT(H)) pif ();

   promediador_ctrl #(.WIDTH(W), .HEIGHT(H), .FILTER_LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (pif)
   );

   logic [11:0]  filt_pipe [LAT];
   logic [11:0]  filter_rgb_out;
   logic [11:0]  frm [H][W];
   logic [107:0] exp_win_q [$];
   exp_t         exp_out_q [$];
   int           n_compared = 0;
   int           n_mismatched = 0;
   int           n_out = 0;
   int           n_fd = 0;

   // Free-running clock
   always #5 clk = ~clk;

   // Per-channel mean of the nine window slots
   function automatic logic [11:0] filterAvg(input logic [107:0] w);
      int sr, sg, sb;
      sr = 0; sg = 0; sb = 0;
      for (int k = 0; k < 9; k++) begin
         sr += int'(w[k*12+8 +: 4]);
         sg += int'(w[k*12+4 +: 4]);
         sb += int'(w[k*12   +: 4]);
      end
      return {4'(sr / 9), 4'(sg / 9), 4'(sb / 9)};
   endfunction

   // Averaging filter with a fixed four-cycle pipeline on win_data
   always @(posedge clk) begin
      filt_pipe[0] <= filterAvg(pif.win_data);
      for (int i = 1; i < LAT; i++) filt_pipe[i] <= filt_pipe[i-1];
   end
   assign filter_rgb_out = filt_pipe[LAT-1];

   function automatic logic [11:0] pixAt(input int x, input int y);
      int cx, cy;
      cx = (x < 0) ? 0 : (x > W-1) ? W-1 : x;
      cy = (y < 0) ? 0 : (y > H-1) ? H-1 : y;
      return frm[cy][cx];
   endfunction

   function automatic logic [107:0] refWindow(input int x, input int y);
      logic [107:0] w;
      w = '0;
      for (int k = 0; k < 9; k++) w[107-12*k -: 12] = pixAt(x + DXT[k], y + DYT[k]);
      return w;
   endfunction

   function automatic logic [11:0] refAverage(input int x, input int y);
      int sr, sg, sb;
      logic [11:0] p;
      sr = 0; sg = 0; sb = 0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            p = pixAt(x + dx, y + dy);
            sr += int'(p[11:8]);
            sg += int'(p[7:4]);
            sb += int'(p[3:0]);
         end
      end
      return {4'(sr / 9), 4'(sg / 9), 4'(sb / 9)};
   endfunction

   task automatic checkOutput(input string tag, input logic [107:0] got, input logic [107:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Checks every emitted window and every filtered output against the queues
   always @(negedge clk) begin : monitor
      logic [107:0] ew;
      exp_t         eo;
      if (!reset) begin
         if (pif.win_valid) begin
            if (exp_win_q.size() == 0) begin
               checkOutput("win_unexpected", 108'd1, 108'd0);
            end else begin
               ew = exp_win_q.pop_front();
               checkOutput("win_data", pif.win_data, ew);
            end
         end
         if (pif.out_valid) begin
            n_out++;
            if (pif.frame_done) n_fd++;
            if (exp_out_q.size() == 0) begin
               checkOutput("out_unexpected", 108'd1, 108'd0);
            end else begin
               eo = exp_out_q.pop_front();
               checkOutput("out_x", pif.out_x, eo.x);
               checkOutput("out_y", pif.out_y, eo.y);
               checkOutput("filter_rgb_out", filter_rgb_out, eo.v);
               checkOutput("frame_done", pif.frame_done, eo.last);
            end
         end else if (pif.frame_done) begin
            checkOutput("frame_done_stray", 108'd1, 108'd0);
         end
      end
   end

   task automatic fillFrame(input int mode, input logic [11:0] val);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            case (mode)
               0:       frm[y][x] = val;
               1:       frm[y][x] = (x == 0 && y == 0) ? val : 12'h000;
               2:       frm[y][x] = 12'(y * W + x);
               default: frm[y][x] = 12'($urandom);
            endcase
         end
      end
   endtask

   task automatic pushExpect();
      exp_t e;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            exp_win_q.push_back(refWindow(x, y));
            e.x    = 8'(x);
            e.y    = 8'(y);
            e.v    = refAverage(x, y);
            e.last = (x == W-1 && y == H-1);
            exp_out_q.push_back(e);
         end
      end
   endtask

   task automatic checkReset();
      checkOutput("rst_pix_ready", pif.pix_ready, 108'd1);
      checkOutput("rst_win_valid", pif.win_valid, 108'd0);
      checkOutput("rst_win_data", pif.win_data, 108'd0);
      checkOutput("rst_out_valid", pif.out_valid, 108'd0);
      checkOutput("rst_out_x", pif.out_x, 108'd0);
      checkOutput("rst_out_y", pif.out_y, 108'd0);
      checkOutput("rst_frame_done", pif.frame_done, 108'd0);
   endtask

   // Presents one pixel after optional idle gaps and returns #1 after it is taken
   task automatic sendPixel(input logic [11:0] p, input int gap_pct);
      int n;
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
         pif.pix_valid = 1'b0;
         @(posedge clk); #1;
      end
      pif.pix_in    = p;
      pif.pix_valid = 1'b1;
      n = 0;
      while (!pif.pix_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 64) checkOutput("accept_timeout", n, 0);
      @(posedge clk); #1;
      pif.pix_valid = 1'b0;
   endtask

   // Counts stalled cycles while offering a junk pixel that must not be consumed
   task automatic measureReadyLow(input int exp_n);
      int n;
      n = 0;
      pif.pix_in    = 12'hFFF;
      pif.pix_valid = 1'b1;
      while (!pif.pix_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      pif.pix_valid = 1'b0;
      checkOutput("ready_low_cycles", n, exp_n);
   endtask

   task automatic applyStimulus(input int gap_pct);
      pushExpect();
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            sendPixel(frm[y][x], gap_pct);
            if (x == W-1) measureReadyLow((y == H-1) ? (1 + (W-1) + 1 + LAT) : 1);
         end
      end
   endtask

   task automatic waitDrain(input int exp_outs, input int exp_fds);
      int n;
      n = 0;
      while ((exp_out_q.size() != 0 || exp_win_q.size() != 0) && n < 400) begin
         @(posedge clk);
         n++;
      end
      repeat (LAT + 4) @(posedge clk);
      #1;
      checkOutput("drain_pending", exp_out_q.size() + exp_win_q.size(), 0);
      checkOutput("out_count", n_out, exp_outs);
      checkOutput("frame_done_count", n_fd, exp_fds);
      n_out = 0;
      n_fd  = 0;
   endtask

   // Main sequence of frames
   initial begin
      reset         = 1'b1;
      pif.pix_valid = 1'b0;
      pif.pix_in    = '0;
      repeat (2) @(posedge clk);
      #1;
      checkReset();
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] constant frame");
      fillFrame(0, 12'hABC); applyStimulus(0);  waitDrain(12, 1);
      $display("[TB] impulse frame");
      fillFrame(1, 12'hF00); applyStimulus(0);  waitDrain(12, 1);
      $display("[TB] ramp frame, no gaps then gaps");
      fillFrame(2, 12'h000); applyStimulus(0);  waitDrain(12, 1);
      fillFrame(2, 12'h000); applyStimulus(50); waitDrain(12, 1);
      $display("[TB] random frames with gaps");
      for (int r = 0; r < 3; r++) begin
         fillFrame(3, 12'h000); applyStimulus(30); waitDrain(12, 1);
      end

      $display("[TB] reset mid-frame");
      fillFrame(3, 12'h000);
      pushExpect();
      for (int i = 0; i < 6; i++) sendPixel(frm[i / W][i % W], 0);
      @(posedge clk); #1;
      reset = 1'b1;
      exp_win_q.delete();
      exp_out_q.delete();
      @(posedge clk); #1;
      checkReset();
      @(posedge clk); #1;
      reset = 1'b0;
      n_out = 0;
      n_fd  = 0;
      fillFrame(0, 12'h123); applyStimulus(0); waitDrain(12, 1);

      $display("[TB] back-to-back frames");
      fillFrame(3, 12'h000); applyStimulus(0);
      fillFrame(0, 12'h5A7); applyStimulus(0);
      waitDrain(24, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/promediador_ctrl.md
Name: promediador_ctrl

Overview:
- Window sequencer for the 3x3 averaging filter (the 108-bit-window, 12-bit RGB444 filter block).
- Accepts a raster-order RGB444 pixel stream and keeps two line buffers.
- Builds a border-replicated 3x3 window per pixel and drives the filter's color_data input.
- Tracks the filter's fixed pipeline latency to emit aligned valid, coordinates and end-of-frame.

Parameters:
- WIDTH, 160, pixels per line (>=2).
- HEIGHT, 120, lines per frame (>=2).
- FILTER_LATENCY, 4, clock cycles from win_data change to the matching filter_rgb_out.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pix_in  in  12  input pixel {R[11:8],G[7:4],B[3:0]}.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  controller accepts pix_in this cycle.
- win_data  out  108  window to filter color_data.
- win_valid  out  1  win_data holds a new window this cycle.
- out_valid  out  1  filter_rgb_out is valid for (out_x, out_y).
- out_x  out  $clog2(WIDTH)  column of the filtered pixel.
- out_y  out  $clog2(HEIGHT)  row of the filtered pixel.
- frame_done  out  1  one-cycle pulse with the last out_valid of a frame.

Behaviour:
- Reset: state RUN; xi=yi=0; pix_ready=1; win_data=0; win_valid=0; out_valid=0; out_x=out_y=0; frame_done=0. Valid/coordinate delay line cleared. Line-buffer contents are don't-care. Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- Acceptance: a pixel is accepted when pix_valid&&pix_ready. Its coordinates are (xi,yi). xi wraps at WIDTH-1 and yi increments.
- win_data packing: [107:96] center, [95:84] left, [83:72] right, [71:60] up, [59:48] down, [47:36] upleft, [35:24] upright, [23:12] downleft, [11:0] downright.
- Emission: accepting (xi,yi) with xi>=1 and yi>=1 emits the window for center (xi-1,yi-1). win_valid=1 and win_data update the next cycle.
- Border handling: replicate the edge pixel. Out-of-range x clamps to 0/WIDTH-1; out-of-range y clamps to 0/HEIGHT-1.
- States:
  - RUN: pix_ready=1. Accepting xi=WIDTH-1 -> EOL.
  - EOL: pix_ready=0 for 1 cycle. If yi(row just completed)>=1, emit center (WIDTH-1, yi-1) with right column replicated. If that row was HEIGHT-1 -> FLUSH, else -> RUN.
  - FLUSH: pix_ready=0 for WIDTH-1 cycles. Emit centers (1..WIDTH-1... i.e. cycles k=1..WIDTH-1 emit (k-1,HEIGHT-1)), with the down row replicating the center row. Then -> FLUSH_EOL.
  - FLUSH_EOL: pix_ready=0 for 1 cycle. Emit (WIDTH-1,HEIGHT-1). -> DRAIN.
  - DRAIN: pix_ready=0 for FILTER_LATENCY cycles, then counters cleared and -> RUN.
- win_valid is 0 in every cycle with no emission. win_data holds its last value in those cycles.
- out_valid/out_x/out_y: win_valid and center coordinates delayed exactly FILTER_LATENCY cycles by a shift register.
- frame_done is asserted with out_valid for (WIDTH-1,HEIGHT-1).
- Count: exactly WIDTH*HEIGHT out_valid pulses per frame, in raster order.
- pix_valid low in RUN: hold all state, no emission. Gaps are allowed anywhere in a line.
- pix_valid during non-RUN states is ignored and not consumed.
- Line buffers: two WIDTH x 12 single-port-read/single-write arrays, rotated per line.
  - Read address = xi.
  - Written with pix_in (row yi) while row yi-1 moves to the second buffer.
  - No read-during-write hazard: read precedes write at the same address.

Decomposition:
- Package promediador_pkg holds:
  - pixel width 12, window width 108;
  - slot offset constants (CENTER=96, LEFT=84, RIGHT=72, UP=60, DOWN=48, UL=36, UR=24, DL=12, DR=0);
  - state enum {RUN, EOL, FLUSH, FLUSH_EOL, DRAIN}.
- Sub-module line_buffer: WIDTH-deep 12-bit RAM, registered read. Instantiate twice.

Test Plan (WIDTH=4, HEIGHT=3, FILTER_LATENCY=4, filter instantiated in bench):
- Constant frame 12'hABC, pix_valid always 1 -> 12 out_valid pulses with filter_rgb_out=12'hABC, raster coordinates (0,0)..(3,2), frame_done only with (3,2).
- Impulse 12'hF00 at (0,0), others 0 -> win_data for center (0,0) has center/left/up/upleft=12'hF00, rest 0; win_data for (1,1) has only upleft=12'hF00.
- Handshake timing -> pix_ready low exactly 1 cycle after each xi=3 acceptance. After the last pixel: low for 1+3+1+4=9 cycles, then high with xi=yi=0.
- Random pix_valid gaps (50%) on ramp frame pix=index -> identical win_data sequence and out_x/out_y order as the gap-free run.
- reset pulsed after 6 accepted pixels, then a full constant 12'h123 frame -> no out_valid from the aborted frame beyond those emitted before reset plus in-flight ones cleared. New frame yields 12 outputs of 12'h123.
- Back-to-back frames -> second frame's first pixel accepted the cycle after DRAIN ends. 24 out_valid total, 2 frame_done pulses.
